// File: rtl/audio_dac_streamer.sv
// FIFO-buffered I2S / left-justified stereo DAC serializer driven by codec-mastered BCLK/LRCK.
// Optional underrun counter (underrun_clr, underrun_count) is built when AUDIO_DAC_UNDERRUN_CNT_EN is defined.
module audio_dac_streamer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned I2S_MODE     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_WIDTH-1:0]       s_left,
  input  logic [SAMPLE_WIDTH-1:0]       s_right,
  input  logic                          bclk_in,
  input  logic                          lrck_in,
  output logic                          dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  ,
  input  logic                          underrun_clr,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(SLOT_WIDTH + 1);
  localparam int unsigned IW = $clog2(SAMPLE_WIDTH);

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } frame_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, next_state;
  logic [1:0]              bclk_sync, lrck_sync;
  logic                    bclk_prev, lrck_last;
  logic                    bclk_fall, lrck_s, lrck_edge, left_start;
  frame_t                  mem [FIFO_DEPTH];
  frame_t                  head;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level_next;
  logic                    push, pop, empty;
  logic                    load_frame, underrun_c;
  logic [CW-1:0]           bit_cnt, cnt_now;
  logic [SAMPLE_WIDTH-1:0] left_sr, right_sr, left_now, right_now, sample;
  logic                    bit_c;
  int                      pos;

  // Codec clocks are asynchronous: two-flop synchronisers plus a BCLK history flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_last <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk_in};
      lrck_sync <= {lrck_sync[0], lrck_in};
      bclk_prev <= bclk_sync[1];
      if (bclk_fall) lrck_last <= lrck_s;
    end
  end

  assign bclk_fall  = bclk_prev & ~bclk_sync[1];
  assign lrck_s     = lrck_sync[1];
  assign lrck_edge  = bclk_fall & (lrck_s ^ lrck_last);
  assign left_start = lrck_edge & ~lrck_s;

  assign push  = s_valid & s_ready;
  assign empty = (fifo_level == '0);
  assign pop   = load_frame & ~empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_left, s_right};
  end

  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      s_ready    <= (level_next != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Frame decisions are taken only at a left-channel start.
  always_comb begin
    next_state = state;
    load_frame = 1'b0;
    underrun_c = 1'b0;
    if (left_start) begin
      if (enable) begin
        next_state = RUN;
        load_frame = 1'b1;
        underrun_c = empty;
      end else begin
        next_state = IDLE;
      end
    end
  end

  // Slot bit position; a new frame's MSB must be usable on the very edge it loads.
  always_comb begin
    cnt_now = bit_cnt;
    if (lrck_edge)                          cnt_now = '0;
    else if (bit_cnt != CW'(SLOT_WIDTH))    cnt_now = bit_cnt + CW'(1);
    left_now  = left_sr;
    right_now = right_sr;
    if (pop) begin
      left_now  = head.left;
      right_now = head.right;
    end else if (load_frame) begin
      left_now  = '0;
      right_now = '0;
    end
    sample = lrck_s ? right_now : left_now;
    pos    = int'(cnt_now) - int'(I2S_MODE);
    bit_c  = 1'b0;
    if (next_state == RUN && pos >= 0 && pos < int'(SAMPLE_WIDTH))
      bit_c = sample[IW'(int'(SAMPLE_WIDTH) - 1 - pos)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      left_sr  <= '0;
      right_sr <= '0;
      dacdat   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= underrun_c;
      if (bclk_fall) begin
        bit_cnt <= cnt_now;
        dacdat  <= bit_c;
      end
      if (load_frame) begin
        left_sr  <= left_now;
        right_sr <= right_now;
      end
    end
  end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  // Counts registered underrun pulses; a clear coinciding with a pulse keeps that pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underrun_count <= '0;
    else if (underrun_clr)
      underrun_count <= underrun ? 16'd1 : 16'd0;
    else if (underrun && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: doc/audio_dac_streamer.md
Name: audio_dac_streamer

Overview:
- Parametrised I2S/left-justified DAC serializer: buffers stereo sample frames in a FIFO and shifts them out on DACDAT.
- Timing comes from codec-mastered BCLK/DACLRCK (inputs, asynchronous to clk).
- Sits between the Nios audio DMA/PIO path and the audio_out pins; generalises the fixed 16-bit, unbuffered audio_out conduit with configurable sample and slot width, FIFO depth and framing mode.

Parameters:
SAMPLE_WIDTH, 16, bits per channel sample (8..32)
SLOT_WIDTH, 32, BCLK periods per half-frame (>= SAMPLE_WIDTH)
FIFO_DEPTH, 64, stereo frames buffered; power of 2, >= 4
I2S_MODE, 1, 1 = I2S (MSB one BCLK after LRCK edge), 0 = left-justified (MSB on LRCK edge)

Ports:
clk  in  1  system clock; must be >= 4x BCLK frequency
reset  in  1  asynchronous, active-high reset
enable  in  1  playback enable (level)
s_valid  in  1  frame-write strobe
s_ready  out  1  FIFO not full
s_left  in  SAMPLE_WIDTH  left sample, two's complement
s_right  in  SAMPLE_WIDTH  right sample, two's complement
bclk_in  in  1  codec bit clock (async)
lrck_in  in  1  codec DACLRCK (async); low = left
dacdat  out  1  serial data to codec
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored
underrun  out  1  one-clk pulse when a frame is due and FIFO is empty

Behaviour:
- Reset: dacdat=0, underrun=0, fifo_level=0, s_ready=1 (one cycle after reset release), FIFO empty, state IDLE, shift registers 0.
- Synchronisation: bclk_in and lrck_in each pass through 2-FF synchronisers. A third register gives bclk_fall = prev&~cur. All serial activity happens only on cycles where bclk_fall=1. lrck_s is the synced LRCK sampled on that cycle. lrck_edge = lrck_s differs from lrck_s at the previous bclk_fall.
- FIFO write: push when s_valid && s_ready. Data is SAMPLE_WIDTH*2 wide. s_ready = (level != FIFO_DEPTH).
- FIFO read and push in the same cycle: level unchanged.
- Full FIFO plus a pop in a cycle: no push that cycle, because s_ready was already low.
- State machine:
  - IDLE: dacdat=0. Move to RUN on a bclk_fall with lrck_edge and lrck_s=0 (left start) while enable=1. Frames starting on the right channel are never entered.
  - RUN, at every left start:
    - If enable=0: go to IDLE and drive dacdat=0 from that edge.
    - Else if FIFO is non-empty: pop one frame into left_sr/right_sr.
    - Else: load zeros and pulse underrun for 1 clk.
  - RUN, at right start (lrck_edge, lrck_s=1): switch the source to right_sr. No pop.
- Bit counter: reset to 0 on each lrck_edge. Increments on each bclk_fall and saturates at SLOT_WIDTH.
- Output bit position p = counter - I2S_MODE:
  - 0 <= p < SAMPLE_WIDTH: dacdat = bit (SAMPLE_WIDTH-1-p) of the current channel sample, MSB first.
  - Otherwise: dacdat = 0.
  - dacdat changes only on bclk_fall cycles, so the codec samples it on the BCLK rising edge.
- I2S_MODE=1: MSB on the bclk_fall after the one carrying lrck_edge. I2S_MODE=0: MSB on the same bclk_fall.
- Mid-frame changes: enable going low finishes the current frame. A reset mid-frame aborts immediately, with outputs at reset values.
- Short slots: if the LRCK period is shorter than SAMPLE_WIDTH, the current channel truncates at the next lrck_edge; no error flag.

Optional Feature:
- AUDIO_DAC_UNDERRUN_CNT_EN defined:
  - Adds input underrun_clr (1) and output underrun_count (16).
  - underrun_count increments on every underrun pulse and saturates at 16'hFFFF.
  - underrun_clr has priority, except that clear and underrun in the same cycle gives 1.
  - Reset value 0.
- Undefined: both ports and the counter are absent; behaviour otherwise identical.

Test Plan:
- Reset, enable=1, push L=16'hA5C3, R=16'h0F0F; BCLK=clk/8, LRCK=BCLK/64, I2S_MODE=1 -> after the first left edge, dacdat shows 1010010111000011 starting one BCLK after LRCK falls, then 16 zeros; right slot shows 0000111100001111 with the same offset; fifo_level returns 0.
- Same frame with I2S_MODE=0 -> MSB appears on the first BCLK of the slot; bits are one BCLK earlier than in test 1.
- Push 64 frames with no BCLK -> s_ready=0 at level 64, a 65th s_valid is ignored; after one frame plays, level=63 and s_ready=1.
- Empty FIFO, enable=1, run 3 frames -> 3 underrun pulses, dacdat=0 throughout; with the macro defined, underrun_count=3, and underrun_clr together with a 4th underrun gives 1.
- Drop enable mid-left-slot with 2 frames queued -> current frame completes, then dacdat=0, no further pop, fifo_level stays 1.
- Assert reset mid-right-slot -> dacdat=0 and fifo_level=0 immediately; after release, output restarts only at the next left start.
